// File: rtl/ps2_xt_translator.sv
// ps2_xt_translator: PS/2 scan-code-set-2 keyboard to IBM PC/XT set-1 keyboard port bridge.
//   Deserialises PS/2 frames, checks start/parity/stop, folds F0 break prefixes into set-1 break
//   codes via the AT 8042 translation table, buffers bytes in a FIFO and re-serialises them as
//   XT frames (start bit 1, then 8 data bits LSB first).
// Ports:
//   CLK, RESET_N          system clock, asynchronous active-low reset
//   PS2_CLK, PS2_DATA     keyboard PS/2 lines (asynchronous, synchronised here)
//   XT_INHIBIT            PC holds off transmission while high (level, synchronised here)
//   XT_CLK, XT_DATA       XT keyboard clock/data to the PC (registered)
//   FIFO_LEVEL            number of translated bytes queued
//   OVERFLOW, FRAME_ERR   sticky status flags, cleared by a CLR_STATUS pulse
//   CLR_STATUS            one-cycle clear of both status flags
module ps2_xt_translator #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned HALF_BIT   = 400,
  parameter int unsigned RX_TIMEOUT = 20000,
  parameter int unsigned GAP        = 1600
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        PS2_CLK,
  input  logic                        PS2_DATA,
  input  logic                        XT_INHIBIT,
  output logic                        XT_CLK,
  output logic                        XT_DATA,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                        OVERFLOW,
  output logic                        FRAME_ERR,
  input  logic                        CLR_STATUS
);

  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = AddrW + 1;
  localparam int unsigned ToW    = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned CntMax = (GAP > HALF_BIT) ? GAP : HALF_BIT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {RIdle, RData, RPar, RStop} rx_state_e;
  typedef enum logic [1:0] {TIdle, TStart, TBits, TGap} tx_state_e;

  // ---------------------------------------------------------------- input synchronisers
  logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
  logic ps2_data_s1_q, ps2_data_s2_q;
  logic inhibit_s1_q, inhibit_s2_q;
  logic ps2_fall;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ps2_clk_s1_q   <= 1'b1;
      ps2_clk_s2_q   <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_data_s1_q  <= 1'b1;
      ps2_data_s2_q  <= 1'b1;
      inhibit_s1_q   <= 1'b0;
      inhibit_s2_q   <= 1'b0;
    end else begin
      ps2_clk_s1_q   <= PS2_CLK;
      ps2_clk_s2_q   <= ps2_clk_s1_q;
      ps2_clk_prev_q <= ps2_clk_s2_q;
      ps2_data_s1_q  <= PS2_DATA;
      ps2_data_s2_q  <= ps2_data_s1_q;
      inhibit_s1_q   <= XT_INHIBIT;
      inhibit_s2_q   <= inhibit_s1_q;
    end
  end

  assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_s2_q;

  // ---------------------------------------------------------------- PS/2 receiver
  rx_state_e      rx_state_q;
  logic [7:0]     rx_shift_q;
  logic [2:0]     rx_cnt_q;
  logic           rx_par_q;
  logic [ToW-1:0] rx_to_q;
  logic           rx_valid_q;
  logic [7:0]     rx_byte_q;
  logic           rx_err_q;   // one-cycle error event

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_state_q <= RIdle;
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      rx_par_q   <= 1'b0;
      rx_to_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (rx_state_q == RIdle || ps2_fall) begin
        rx_to_q <= '0;
      end else begin
        rx_to_q <= rx_to_q + 1'b1;
      end
      case (rx_state_q)
        RIdle: begin
          // A high start bit is line noise, not a frame.
          if (ps2_fall && !ps2_data_s2_q) begin
            rx_state_q <= RData;
            rx_cnt_q   <= '0;
          end
        end
        RData: begin
          if (ps2_fall) begin
            rx_shift_q <= {ps2_data_s2_q, rx_shift_q[7:1]};
            rx_cnt_q   <= rx_cnt_q + 1'b1;
            if (rx_cnt_q == 3'd7) rx_state_q <= RPar;
          end
        end
        RPar: begin
          if (ps2_fall) begin
            rx_par_q   <= ps2_data_s2_q;
            rx_state_q <= RStop;
          end
        end
        RStop: begin
          if (ps2_fall) begin
            rx_state_q <= RIdle;
            if (ps2_data_s2_q && (^{rx_shift_q, rx_par_q})) begin
              rx_valid_q <= 1'b1;
              rx_byte_q  <= rx_shift_q;
            end else begin
              rx_err_q <= 1'b1;
            end
          end
        end
        default: rx_state_q <= RIdle;
      endcase
      if (rx_state_q != RIdle && !ps2_fall && rx_to_q == ToW'(RX_TIMEOUT - 1)) begin
        rx_state_q <= RIdle;
        rx_err_q   <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- set 2 -> set 1 ROM
  logic [7:0] xlate;

  always_comb begin
    xlate = rx_byte_q;
    case (rx_byte_q)
      8'h00: xlate = 8'hFF; 8'h01: xlate = 8'h43; 8'h02: xlate = 8'h41; 8'h03: xlate = 8'h3F;
      8'h04: xlate = 8'h3D; 8'h05: xlate = 8'h3B; 8'h06: xlate = 8'h3C; 8'h07: xlate = 8'h58;
      8'h08: xlate = 8'h64; 8'h09: xlate = 8'h44; 8'h0A: xlate = 8'h42; 8'h0B: xlate = 8'h40;
      8'h0C: xlate = 8'h3E; 8'h0D: xlate = 8'h0F; 8'h0E: xlate = 8'h29; 8'h0F: xlate = 8'h59;
      8'h10: xlate = 8'h65; 8'h11: xlate = 8'h38; 8'h12: xlate = 8'h2A; 8'h13: xlate = 8'h70;
      8'h14: xlate = 8'h1D; 8'h15: xlate = 8'h10; 8'h16: xlate = 8'h02; 8'h17: xlate = 8'h5A;
      8'h18: xlate = 8'h66; 8'h19: xlate = 8'h71; 8'h1A: xlate = 8'h2C; 8'h1B: xlate = 8'h1F;
      8'h1C: xlate = 8'h1E; 8'h1D: xlate = 8'h11; 8'h1E: xlate = 8'h03; 8'h1F: xlate = 8'h5B;
      8'h20: xlate = 8'h67; 8'h21: xlate = 8'h2E; 8'h22: xlate = 8'h2D; 8'h23: xlate = 8'h20;
      8'h24: xlate = 8'h12; 8'h25: xlate = 8'h05; 8'h26: xlate = 8'h04; 8'h27: xlate = 8'h5C;
      8'h28: xlate = 8'h68; 8'h29: xlate = 8'h39; 8'h2A: xlate = 8'h2F; 8'h2B: xlate = 8'h21;
      8'h2C: xlate = 8'h14; 8'h2D: xlate = 8'h13; 8'h2E: xlate = 8'h06; 8'h2F: xlate = 8'h5D;
      8'h30: xlate = 8'h69; 8'h31: xlate = 8'h31; 8'h32: xlate = 8'h30; 8'h33: xlate = 8'h23;
      8'h34: xlate = 8'h22; 8'h35: xlate = 8'h15; 8'h36: xlate = 8'h07; 8'h37: xlate = 8'h5E;
      8'h38: xlate = 8'h6A; 8'h39: xlate = 8'h72; 8'h3A: xlate = 8'h32; 8'h3B: xlate = 8'h24;
      8'h3C: xlate = 8'h16; 8'h3D: xlate = 8'h08; 8'h3E: xlate = 8'h09; 8'h3F: xlate = 8'h5F;
      8'h40: xlate = 8'h6B; 8'h41: xlate = 8'h33; 8'h42: xlate = 8'h25; 8'h43: xlate = 8'h17;
      8'h44: xlate = 8'h18; 8'h45: xlate = 8'h0B; 8'h46: xlate = 8'h0A; 8'h47: xlate = 8'h60;
      8'h48: xlate = 8'h6C; 8'h49: xlate = 8'h34; 8'h4A: xlate = 8'h35; 8'h4B: xlate = 8'h26;
      8'h4C: xlate = 8'h27; 8'h4D: xlate = 8'h19; 8'h4E: xlate = 8'h0C; 8'h4F: xlate = 8'h61;
      8'h50: xlate = 8'h6D; 8'h51: xlate = 8'h73; 8'h52: xlate = 8'h28; 8'h53: xlate = 8'h74;
      8'h54: xlate = 8'h1A; 8'h55: xlate = 8'h0D; 8'h56: xlate = 8'h62; 8'h57: xlate = 8'h6E;
      8'h58: xlate = 8'h3A; 8'h59: xlate = 8'h36; 8'h5A: xlate = 8'h1C; 8'h5B: xlate = 8'h1B;
      8'h5C: xlate = 8'h75; 8'h5D: xlate = 8'h2B; 8'h5E: xlate = 8'h63; 8'h5F: xlate = 8'h76;
      8'h60: xlate = 8'h55; 8'h61: xlate = 8'h56; 8'h62: xlate = 8'h77; 8'h63: xlate = 8'h78;
      8'h64: xlate = 8'h79; 8'h65: xlate = 8'h7A; 8'h66: xlate = 8'h0E; 8'h67: xlate = 8'h7B;
      8'h68: xlate = 8'h7C; 8'h69: xlate = 8'h4F; 8'h6A: xlate = 8'h7D; 8'h6B: xlate = 8'h4B;
      8'h6C: xlate = 8'h47; 8'h6D: xlate = 8'h7E; 8'h6E: xlate = 8'h7F; 8'h6F: xlate = 8'h6F;
      8'h70: xlate = 8'h52; 8'h71: xlate = 8'h53; 8'h72: xlate = 8'h50; 8'h73: xlate = 8'h4C;
      8'h74: xlate = 8'h4D; 8'h75: xlate = 8'h48; 8'h76: xlate = 8'h01; 8'h77: xlate = 8'h45;
      8'h78: xlate = 8'h57; 8'h79: xlate = 8'h4E; 8'h7A: xlate = 8'h51; 8'h7B: xlate = 8'h4A;
      8'h7C: xlate = 8'h37; 8'h7D: xlate = 8'h49; 8'h7E: xlate = 8'h46; 8'h7F: xlate = 8'h54;
      8'h83: xlate = 8'h41; 8'h84: xlate = 8'h54;
      default: xlate = rx_byte_q;
    endcase
  end

  // ---------------------------------------------------------------- break merge
  logic       break_pend_q;
  logic       is_prefix;
  logic       push_req;
  logic [7:0] push_data;

  always_comb begin
    is_prefix = (rx_byte_q == 8'hE0) || (rx_byte_q == 8'hE1);
    push_req  = rx_valid_q && (rx_byte_q != 8'hF0);
    push_data = is_prefix ? rx_byte_q : (xlate | {break_pend_q, 7'b0});
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      break_pend_q <= 1'b0;
    end else if (rx_valid_q) begin
      if (rx_byte_q == 8'hF0) begin
        break_pend_q <= 1'b1;
      end else if (!is_prefix) begin
        break_pend_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  count_q;
  logic             fifo_full, fifo_empty, push, pop;
  tx_state_e        tx_state_q;

  always_comb begin
    fifo_full  = (count_q == LvlW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    pop        = (tx_state_q == TIdle) && !fifo_empty && !inhibit_s2_q;
    // When full, a same-cycle pop frees the slot being written.
    push       = push_req && (!fifo_full || pop);
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- sticky status
  logic overflow_q, frame_err_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // Set has priority over a coincident clear.
      if (push_req && !push) begin
        overflow_q <= 1'b1;
      end else if (CLR_STATUS) begin
        overflow_q <= 1'b0;
      end
      if (rx_err_q) begin
        frame_err_q <= 1'b1;
      end else if (CLR_STATUS) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- XT transmitter
  logic [8:0]      tx_shift_q;  // bit 0 is the bit on the wire
  logic [3:0]      tx_bit_q;
  logic            tx_low_q;    // 1 while in the XT_CLK=0 half of a bit
  logic [CntW-1:0] tx_cnt_q;
  logic            xt_clk_q, xt_data_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_state_q <= TIdle;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      tx_low_q   <= 1'b0;
      tx_cnt_q   <= '0;
      xt_clk_q   <= 1'b1;
      xt_data_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        TIdle: begin
          xt_clk_q  <= 1'b1;
          xt_data_q <= 1'b1;
          if (pop) begin
            tx_shift_q <= {fifo_mem[rd_ptr_q], 1'b1};
            tx_state_q <= TStart;
          end
        end
        TStart: begin
          // One setup cycle: drive the start bit, then the first high half begins.
          xt_data_q  <= tx_shift_q[0];
          tx_cnt_q   <= '0;
          tx_bit_q   <= '0;
          tx_low_q   <= 1'b0;
          tx_state_q <= TBits;
        end
        TBits: begin
          if (tx_cnt_q == CntW'(HALF_BIT - 1)) begin
            tx_cnt_q <= '0;
            if (!tx_low_q) begin
              xt_clk_q <= 1'b0;
              tx_low_q <= 1'b1;
            end else begin
              xt_clk_q <= 1'b1;
              tx_low_q <= 1'b0;
              if (tx_bit_q == 4'd8) begin
                xt_data_q  <= 1'b1;
                tx_state_q <= TGap;
              end else begin
                tx_bit_q   <= tx_bit_q + 1'b1;
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                xt_data_q  <= tx_shift_q[1];
              end
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TGap: begin
          if (tx_cnt_q == CntW'(GAP - 1)) begin
            tx_state_q <= TIdle;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TIdle;
      endcase
    end
  end

  assign XT_CLK     = xt_clk_q;
  assign XT_DATA    = xt_data_q;
  assign FIFO_LEVEL = count_q;
  assign OVERFLOW   = overflow_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_ps2_xt_translator.sv
// Bench for ps2_xt_translator: PS/2 frames in, XT frames captured by a PC-side monitor and
// compared against a byte-level model of the set 2 -> set 1 translation.
module tb_ps2_xt_translator;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned HALF_BIT   = 4;
  localparam int unsigned RX_TIMEOUT = 300;
  localparam int unsigned GAP        = 8;
  localparam int          PS2_HALF   = 15;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic PS2_CLK = 1'b1;
  logic PS2_DATA = 1'b1;
  logic XT_INHIBIT = 1'b0;
  logic CLR_STATUS = 1'b0;
  logic XT_CLK, XT_DATA, OVERFLOW, FRAME_ERR;
  logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  logic [8:0] got_q[$];
  logic       model_bp = 1'b0;
  logic [7:0] tab_lo [128];

  always #5 CLK = ~CLK;

  ps2_xt_translator #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .HALF_BIT  (HALF_BIT),
    .RX_TIMEOUT(RX_TIMEOUT),
    .GAP       (GAP)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .XT_INHIBIT(XT_INHIBIT),
    .XT_CLK    (XT_CLK),
    .XT_DATA   (XT_DATA),
    .FIFO_LEVEL(FIFO_LEVEL),
    .OVERFLOW  (OVERFLOW),
    .FRAME_ERR (FRAME_ERR),
    .CLR_STATUS(CLR_STATUS)
  );

  // PC side: the bit committed on an XT_CLK rise is the data held during the low half.
  logic       mon_prev_clk = 1'b1;
  logic       mon_low_data = 1'b1;
  logic [8:0] mon_sr = '0;
  int         mon_n = 0;

  always @(negedge CLK) begin
    if (!RESET_N) begin
      mon_n = 0;
      mon_prev_clk = 1'b1;
    end else begin
      if (!mon_prev_clk && XT_CLK) begin
        mon_sr[mon_n] = mon_low_data;
        mon_n++;
        if (mon_n == 9) begin
          got_q.push_back(mon_sr);
          mon_n = 0;
        end
      end
      if (!XT_CLK) mon_low_data = XT_DATA;
      mon_prev_clk = XT_CLK;
    end
  end

  // ---------------------------------------------------------------- reference model
  function automatic logic [7:0] xlate(input logic [7:0] b);
    if (b == 8'h83) return 8'h41;
    if (b == 8'h84) return 8'h54;
    if (b >= 8'h80) return b;
    return tab_lo[b[6:0]];
  endfunction

  task automatic model_rx(input logic [7:0] b);
    if (b == 8'hF0) begin
      model_bp = 1'b1;
    end else if (b == 8'hE0 || b == 8'hE1) begin
      exp_q.push_back(b);
    end else begin
      exp_q.push_back(model_bp ? (xlate(b) | 8'h80) : xlate(b));
      model_bp = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------- PS/2 driver
  task automatic ps2_bit(input logic v);
    PS2_DATA = v;
    repeat (PS2_HALF) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (PS2_HALF) @(negedge CLK);
    PS2_CLK = 1'b1;
  endtask

  task automatic ps2_frame(input logic [7:0] b, input logic par_flip, input logic stop_v);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ par_flip);
    ps2_bit(stop_v);
    PS2_DATA = 1'b1;
    repeat (PS2_HALF) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b);
    ps2_frame(b, 1'b0, 1'b1);
    model_rx(b);
  endtask

  task automatic wait_drain(output logic ok);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    ok = (got_q.size() >= exp_q.size());
    repeat (200) @(negedge CLK);
  endtask

  task automatic pulse_clr();
    CLR_STATUS = 1'b1;
    @(negedge CLK);
    CLR_STATUS = 1'b0;
    @(negedge CLK);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (XT_CLK !== 1'b1) begin bad++; $display("FAIL reset_xt_clk got %b want 1", XT_CLK); end
    total++; if (XT_DATA !== 1'b1) begin bad++; $display("FAIL reset_xt_data got %b want 1", XT_DATA); end
    total++; if (FIFO_LEVEL !== '0) begin bad++; $display("FAIL reset_level got %0d want 0", FIFO_LEVEL); end
    total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL reset_overflow got %b want 0", OVERFLOW); end
    total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL reset_frame_err got %b want 0", FRAME_ERR); end
    RESET_N = 1'b1;
    repeat (5) @(negedge CLK);
    total++; if (XT_CLK !== 1'b1 || XT_DATA !== 1'b1) begin
      bad++; $display("FAIL idle_lines got clk=%b data=%b want 1 1", XT_CLK, XT_DATA);
    end
  endtask

  task automatic test_single();
    int n;
    logic ok;
    fork
      send(8'h1C);
      begin
        n = 0;
        while (FIFO_LEVEL !== 1 && n < 2000) begin @(negedge CLK); n++; end
        total++; if (FIFO_LEVEL !== 1) begin bad++; $display("FAIL level_rise got %0d want 1", FIFO_LEVEL); end
        @(negedge CLK);
        n = 1;
        total++; if (FIFO_LEVEL !== 0) begin bad++; $display("FAIL level_fall got %0d want 0", FIFO_LEVEL); end
        while (XT_CLK !== 1'b0 && n < 100) begin @(negedge CLK); n++; end
        total++; if (n != HALF_BIT + 2) begin
          bad++; $display("FAIL first_fall_latency got %0d want %0d", n, HALF_BIT + 2);
        end
      end
    join
    wait_drain(ok);
    total++; if (!ok || got_q.size() != 1) begin
      bad++; $display("FAIL single_count got %0d want 1", got_q.size());
    end else begin
      total++; if (got_q[0] !== 9'b0_0011_1101) begin
        bad++; $display("FAIL single_bits got %b want %b", got_q[0], 9'b0_0011_1101);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_break();
    logic ok;
    send(8'hF0); send(8'h1C); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75);
    wait_drain(ok);
    total++; if (!ok || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL break_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i][8:1] !== exp_q[i] || got_q[i][0] !== 1'b1) begin
        bad++; $display("FAIL break_byte%0d got %h want %h", i, got_q[i], {exp_q[i], 1'b1});
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_errors();
    ps2_frame(8'h1C, 1'b1, 1'b1);
    repeat (200) @(negedge CLK);
    total++; if (FRAME_ERR !== 1'b1) begin bad++; $display("FAIL parity_err got %b want 1", FRAME_ERR); end
    total++; if (got_q.size() != 0 || FIFO_LEVEL !== 0) begin
      bad++; $display("FAIL parity_dropped got %0d bytes want 0", got_q.size());
    end
    pulse_clr();
    total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL clr_status got %b want 0", FRAME_ERR); end
    ps2_frame(8'h5A, 1'b0, 1'b0);
    repeat (200) @(negedge CLK);
    total++; if (FRAME_ERR !== 1'b1 || got_q.size() != 0) begin
      bad++; $display("FAIL stop_err got err=%b bytes=%0d want 1 0", FRAME_ERR, got_q.size());
    end
    pulse_clr();
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    logic ok;
    for (int i = 0; i < 4; i++) ps2_bit((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
    repeat (RX_TIMEOUT - 40) @(negedge CLK);
    total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL timeout_early got %b want 0", FRAME_ERR); end
    repeat (80) @(negedge CLK);
    total++; if (FRAME_ERR !== 1'b1) begin bad++; $display("FAIL timeout_err got %b want 1", FRAME_ERR); end
    pulse_clr();
    send(8'h16);
    wait_drain(ok);
    total++; if (!ok || got_q.size() != 1) begin
      bad++; $display("FAIL after_timeout_count got %0d want 1", got_q.size());
    end else begin
      total++; if (got_q[0] !== {8'h02, 1'b1}) begin
        bad++; $display("FAIL after_timeout_byte got %h want %h", got_q[0], {8'h02, 1'b1});
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    logic ok;
    logic [7:0] b;
    XT_INHIBIT = 1'b1;
    repeat (5) @(negedge CLK);
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      b = 8'($urandom_range(1, 127));
      ps2_frame(b, 1'b0, 1'b1);
      if (i < FIFO_DEPTH) model_rx(b);
    end
    repeat (20) @(negedge CLK);
    total++; if (FIFO_LEVEL !== FIFO_DEPTH) begin
      bad++; $display("FAIL full_level got %0d want %0d", FIFO_LEVEL, FIFO_DEPTH);
    end
    total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL overflow got %b want 1", OVERFLOW); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL inhibited_tx got %0d want 0", got_q.size()); end
    XT_INHIBIT = 1'b0;
    wait_drain(ok);
    total++; if (!ok || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL drain_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i][8:1] !== exp_q[i] || got_q[i][0] !== 1'b1) begin
        bad++; $display("FAIL drain_byte%0d got %h want %h", i, got_q[i], {exp_q[i], 1'b1});
      end
    end
    total++; if (FIFO_LEVEL !== 0) begin bad++; $display("FAIL drained_level got %0d want 0", FIFO_LEVEL); end
    pulse_clr();
    total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL overflow_clr got %b want 0", OVERFLOW); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic ok;
    int sel;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2)       send(8'hF0);
      else if (sel == 2) send(($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hE1);
      else               send(8'($urandom_range(0, 255)));
    end
    send(8'h66);
    wait_drain(ok);
    total++; if (!ok || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i][8:1] !== exp_q[i] || got_q[i][0] !== 1'b1) begin
        bad++; $display("FAIL random_byte%0d got %h want %h", i, got_q[i], {exp_q[i], 1'b1});
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    tab_lo = '{
      8'hFF, 8'h43, 8'h41, 8'h3F, 8'h3D, 8'h3B, 8'h3C, 8'h58, 8'h64, 8'h44, 8'h42, 8'h40,
      8'h3E, 8'h0F, 8'h29, 8'h59,
      8'h65, 8'h38, 8'h2A, 8'h70, 8'h1D, 8'h10, 8'h02, 8'h5A, 8'h66, 8'h71, 8'h2C, 8'h1F,
      8'h1E, 8'h11, 8'h03, 8'h5B,
      8'h67, 8'h2E, 8'h2D, 8'h20, 8'h12, 8'h05, 8'h04, 8'h5C, 8'h68, 8'h39, 8'h2F, 8'h21,
      8'h14, 8'h13, 8'h06, 8'h5D,
      8'h69, 8'h31, 8'h30, 8'h23, 8'h22, 8'h15, 8'h07, 8'h5E, 8'h6A, 8'h72, 8'h32, 8'h24,
      8'h16, 8'h08, 8'h09, 8'h5F,
      8'h6B, 8'h33, 8'h25, 8'h17, 8'h18, 8'h0B, 8'h0A, 8'h60, 8'h6C, 8'h34, 8'h35, 8'h26,
      8'h27, 8'h19, 8'h0C, 8'h61,
      8'h6D, 8'h73, 8'h28, 8'h74, 8'h1A, 8'h0D, 8'h62, 8'h6E, 8'h3A, 8'h36, 8'h1C, 8'h1B,
      8'h75, 8'h2B, 8'h63, 8'h76,
      8'h55, 8'h56, 8'h77, 8'h78, 8'h79, 8'h7A, 8'h0E, 8'h7B, 8'h7C, 8'h4F, 8'h7D, 8'h4B,
      8'h47, 8'h7E, 8'h7F, 8'h6F,
      8'h52, 8'h53, 8'h50, 8'h4C, 8'h4D, 8'h48, 8'h01, 8'h45, 8'h57, 8'h4E, 8'h51, 8'h4A,
      8'h37, 8'h49, 8'h46, 8'h54
    };
    test_reset();
    test_single();
    test_break();
    test_frame_errors();
    test_timeout();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
